// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND display controller.
package fnd_pkg;

  // Converter FSM states
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_e;

  // Width of the adder result {carry, sum}
  localparam int unsigned VAL_W      = 9;
  localparam int unsigned NUM_DIGITS = 4;

  // Active-low segment codes, bit7 = dp (off), bits 6:0 = g..a
  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  // Map one BCD nibble to its segment pattern; non-decimal nibbles go dark
  function automatic logic [7:0] font_of(input logic [3:0] nib);
    logic [7:0] f;
    unique case (nib)
      4'd0:    f = FONT_0;
      4'd1:    f = FONT_1;
      4'd2:    f = FONT_2;
      4'd3:    f = FONT_3;
      4'd4:    f = FONT_4;
      4'd5:    f = FONT_5;
      4'd6:    f = FONT_6;
      4'd7:    f = FONT_7;
      4'd8:    f = FONT_8;
      4'd9:    f = FONT_9;
      default: f = FONT_BLANK;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fnd_controller_bin2bcd_seq.sv
// Sequential double-dabble converter: 9-bit binary to 4-digit BCD.
// One load cycle, nine shift cycles, one commit cycle; done pulses once after commit.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [VAL_W-1:0] value,
  output logic [15:0]      bcd,
  output logic             done,
  output logic             busy
);

  conv_state_e      state_q, state_d;
  logic [VAL_W-1:0] shreg_q;
  logic [15:0]      acc_q;
  logic [15:0]      adj;
  logic [3:0]       cnt_q;
  logic [15:0]      bcd_q;
  logic             done_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: load, nine shifts, commit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == 4'(VAL_W - 1)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction on every nibble >= 5 ahead of the shift
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // Datapath: capture, shift, and commit the result with a one-cycle done pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_q == COMMIT);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            shreg_q <= value;
            acc_q   <= '0;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          acc_q   <= {adj[14:0], shreg_q[VAL_W-1]};
          shreg_q <= {shreg_q[VAL_W-2:0], 1'b0};
          cnt_q   <= cnt_q + 4'd1;
        end
        COMMIT:  bcd_q <= acc_q;
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
    bcd  = bcd_q;
  end

endmodule

// File: rtl/fnd_controller.sv
// 4-digit common-anode FND driver for the adder result {carry, sum}.
// Converts changes to BCD in the background and scans the last committed value.
module fnd_controller
  import fnd_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] sum,
  input  logic       carry,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_font,
  output logic       busy
);

  localparam int unsigned TickW = $clog2(TICK_DIV);

  logic [VAL_W-1:0] in_val;
  logic [VAL_W-1:0] last_val_q;
  logic [15:0]      disp_q;
  logic [15:0]      bcd;
  logic             done;
  logic             conv_busy;
  logic             start;
  logic [TickW-1:0] tick_q;
  logic [1:0]       digit_sel_q;
  logic [3:0]       nib;
  logic             blank;

  assign in_val = {carry, sum};
  // Hold off while the result is still being handed over so the commit cycle is not overlapped
  assign start  = !conv_busy && !done && (in_val != last_val_q);
  assign busy   = conv_busy;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .value   (in_val),
    .bcd     (bcd),
    .done    (done),
    .busy    (conv_busy)
  );

  // Change detection and atomic display update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_val_q <= '0;
      disp_q     <= '0;
    end else begin
      if (start) last_val_q <= in_val;
      if (done)  disp_q     <= bcd;
    end
  end

  // Digit scan: dwell TICK_DIV cycles per digit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q      <= '0;
      digit_sel_q <= '0;
    end else if (tick_q == TickW'(TICK_DIV - 1)) begin
      tick_q      <= '0;
      digit_sel_q <= digit_sel_q + 2'd1;
    end else begin
      tick_q <= tick_q + 1'b1;
    end
  end

  // Digit enable and segment mux with leading-zero blanking
  always_comb begin
    nib     = disp_q[{digit_sel_q, 2'b00} +: 4];
    fnd_com = ~(4'b0001 << digit_sel_q);
    // Blank when this digit and everything above it is zero; never the ones digit
    blank   = (digit_sel_q != 2'd0) && ((disp_q >> {digit_sel_q, 2'b00}) == 16'h0);
    if (BLANK_LZ && blank) fnd_font = FONT_BLANK;
    else                   fnd_font = font_of(nib);
  end

endmodule

// File: tb/tb_fnd_controller.sv
// Directed bench for fnd_controller with a fast scan (TICK_DIV = 4).
module tb_fnd_controller;

  localparam int unsigned TICK = 4;

  logic       clk;
  logic       reset_n;
  logic [7:0] sum;
  logic       carry;
  logic [3:0] fnd_com, fnd_com2;
  logic [7:0] fnd_font, fnd_font2;
  logic       busy, busy2;

  int passed = 0;
  int total  = 0;
  int cyc;

  fnd_controller #(.TICK_DIV(TICK), .BLANK_LZ(1'b1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sum      (sum),
    .carry    (carry),
    .fnd_com  (fnd_com),
    .fnd_font (fnd_font),
    .busy     (busy)
  );

  fnd_controller #(.TICK_DIV(TICK), .BLANK_LZ(1'b0)) dut_nb (
    .clk      (clk),
    .reset_n  (reset_n),
    .sum      (sum),
    .carry    (carry),
    .fnd_com  (fnd_com2),
    .fnd_font (fnd_font2),
    .busy     (busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges since last reset release; gives the expected digit position
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  function automatic int exp_digit();
    return (cyc / TICK) % 4;
  endfunction

  function automatic logic [3:0] exp_com(input int d);
    logic [3:0] pat [4];
    pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    return pat[d];
  endfunction

  function automatic logic [7:0] exp_font(input logic [15:0] val, input int d, input bit blz);
    logic [7:0] seg [10];
    logic [3:0] nib;
    bit         all_zero;
    seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    nib = val[d*4 +: 4];
    all_zero = 1'b1;
    for (int j = d; j < 4; j++) if (val[j*4 +: 4] != 4'd0) all_zero = 1'b0;
    if (blz && d != 0 && all_zero) return 8'hFF;
    if (nib > 4'd9) return 8'hFF;
    return seg[nib];
  endfunction

  task automatic test_reset();
    int d;
    reset_n = 1'b0;
    sum     = 8'd0;
    carry   = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (fnd_com !== 4'b1110) $display("FAIL reset_com got=%b want=1110", fnd_com);
    else passed++;
    total++;
    if (fnd_font !== 8'hC0) $display("FAIL reset_font got=%h want=c0", fnd_font);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy);
    else passed++;
    reset_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      d = exp_digit();
      total++;
      if (fnd_com !== exp_com(d)) $display("FAIL reset_scan_com got=%b want=%b", fnd_com, exp_com(d));
      else passed++;
      total++;
      if (fnd_font !== exp_font(16'h0000, d, 1'b1))
        $display("FAIL reset_scan_font d=%0d got=%h want=%h", d, fnd_font, exp_font(16'h0000, d, 1'b1));
      else passed++;
      total++;
      if (busy !== 1'b0) $display("FAIL reset_idle_busy got=%b want=0", busy);
      else passed++;
    end
  endtask

  task automatic test_255();
    int d;
    sum   = 8'd255;
    carry = 1'b0;
    // Samples after capture edge N through N+9 must all show busy
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b1) $display("FAIL busy255_high k=%0d got=%b want=1", k, busy);
      else passed++;
    end
    total++;
    if (dut.disp_q !== 16'h0000) $display("FAIL disp255_early got=%h want=0000", dut.disp_q);
    else passed++;
    @(negedge clk);  // after N+10
    total++;
    if (busy !== 1'b0) $display("FAIL busy255_low got=%b want=0", busy);
    else passed++;
    total++;
    if (dut.disp_q !== 16'h0000) $display("FAIL disp255_n10 got=%h want=0000", dut.disp_q);
    else passed++;
    @(negedge clk);  // after N+11
    total++;
    if (dut.disp_q !== 16'h0255) $display("FAIL disp255 got=%h want=0255", dut.disp_q);
    else passed++;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      d = exp_digit();
      total++;
      if (fnd_font !== exp_font(16'h0255, d, 1'b1))
        $display("FAIL font255 d=%0d got=%h want=%h", d, fnd_font, exp_font(16'h0255, d, 1'b1));
      else passed++;
      total++;
      if (busy !== 1'b0) $display("FAIL busy255_stable got=%b want=0", busy);
      else passed++;
    end
  endtask

  task automatic test_300();
    int d;
    sum   = 8'd44;
    carry = 1'b1;
    repeat (12) @(negedge clk);
    total++;
    if (dut.disp_q !== 16'h0300) $display("FAIL disp300 got=%h want=0300", dut.disp_q);
    else passed++;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      d = exp_digit();
      total++;
      if (fnd_font !== exp_font(16'h0300, d, 1'b1))
        $display("FAIL font300 d=%0d got=%h want=%h", d, fnd_font, exp_font(16'h0300, d, 1'b1));
      else passed++;
    end
  endtask

  task automatic test_max_and_skip();
    int d;
    sum   = 8'hFE;
    carry = 1'b1;
    repeat (3) @(negedge clk);  // after N+2, inside SHIFT
    sum   = 8'd7;
    carry = 1'b0;
    repeat (9) @(negedge clk);  // after N+11
    total++;
    if (dut.disp_q !== 16'h0510) $display("FAIL disp510 got=%h want=0510", dut.disp_q);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL busy_commit_gap got=%b want=0", busy);
    else passed++;
    @(negedge clk);  // after N+12: newest value captured
    total++;
    if (busy !== 1'b1) $display("FAIL busy_recapture got=%b want=1", busy);
    else passed++;
    repeat (10) @(negedge clk);  // after N+22
    total++;
    if (dut.disp_q !== 16'h0510) $display("FAIL disp510_hold got=%h want=0510", dut.disp_q);
    else passed++;
    @(negedge clk);  // after N+23
    total++;
    if (dut.disp_q !== 16'h0007) $display("FAIL disp7 got=%h want=0007", dut.disp_q);
    else passed++;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      d = exp_digit();
      total++;
      if (fnd_font !== exp_font(16'h0007, d, 1'b1))
        $display("FAIL font7 d=%0d got=%h want=%h", d, fnd_font, exp_font(16'h0007, d, 1'b1));
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int d;
    sum   = 8'd123;
    carry = 1'b0;
    repeat (4) @(negedge clk);  // mid-SHIFT
    reset_n = 1'b0;
    #1;
    total++;
    if (dut.disp_q !== 16'h0000) $display("FAIL midrst_disp got=%h want=0000", dut.disp_q);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL midrst_busy got=%b want=0", busy);
    else passed++;
    total++;
    if (fnd_com !== 4'b1110 || fnd_font !== 8'hC0)
      $display("FAIL midrst_out got=%b/%h want=1110/c0", fnd_com, fnd_font);
    else passed++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);  // after first IDLE edge M: capture of 123
    total++;
    if (busy !== 1'b1) $display("FAIL midrst_restart got=%b want=1", busy);
    else passed++;
    repeat (10) @(negedge clk);  // after M+10
    total++;
    if (dut.disp_q !== 16'h0000) $display("FAIL disp123_early got=%h want=0000", dut.disp_q);
    else passed++;
    @(negedge clk);  // after M+11
    total++;
    if (dut.disp_q !== 16'h0123) $display("FAIL disp123 got=%h want=0123", dut.disp_q);
    else passed++;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      d = exp_digit();
      total++;
      if (fnd_font !== exp_font(16'h0123, d, 1'b1))
        $display("FAIL font123 d=%0d got=%h want=%h", d, fnd_font, exp_font(16'h0123, d, 1'b1));
      else passed++;
    end
  endtask

  task automatic test_no_blank();
    int d;
    sum   = 8'd5;
    carry = 1'b0;
    repeat (12) @(negedge clk);
    total++;
    if (dut_nb.disp_q !== 16'h0005) $display("FAIL disp5_nb got=%h want=0005", dut_nb.disp_q);
    else passed++;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      d = exp_digit();
      total++;
      if (fnd_com2 !== exp_com(d)) $display("FAIL nb_com got=%b want=%b", fnd_com2, exp_com(d));
      else passed++;
      total++;
      if (fnd_font2 !== exp_font(16'h0005, d, 1'b0))
        $display("FAIL nb_font d=%0d got=%h want=%h", d, fnd_font2, exp_font(16'h0005, d, 1'b0));
      else passed++;
      total++;
      if (fnd_font !== exp_font(16'h0005, d, 1'b1))
        $display("FAIL blz_font5 d=%0d got=%h want=%h", d, fnd_font, exp_font(16'h0005, d, 1'b1));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_255();
    test_300();
    test_max_and_skip();
    test_reset_mid();
    test_no_blank();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
